// File: rtl/video_pattern_timing_gen_if.sv
// ----------------------------------------------------------------------------
// video_pattern_timing_gen_if
// Groups the control inputs and the video output bus of the pattern/timing
// generator.
//   Enable      : 1 = run timing, 0 = hold counters at 0 and idle the outputs
//   Mode[2:0]   : pattern select, taken up at frame start only
//   HS/VS/DE    : sync and data-enable outputs
//   R/G/B       : colour channels, COLOR_WIDTH bits each
//   FrameStart  : one-cycle pulse with the first active pixel of a frame
// master = generator side, slave = video sink / controlling side.
// ----------------------------------------------------------------------------
interface video_pattern_timing_gen_if #(
  parameter int COLOR_WIDTH = 8
);
  logic                   Enable;
  logic [2:0]             Mode;
  logic                   HS;
  logic                   VS;
  logic                   DE;
  logic [COLOR_WIDTH-1:0] R;
  logic [COLOR_WIDTH-1:0] G;
  logic [COLOR_WIDTH-1:0] B;
  logic                   FrameStart;

  modport master (
    input  Enable, Mode,
    output HS, VS, DE, R, G, B, FrameStart
  );

  modport slave (
    output Enable, Mode,
    input  HS, VS, DE, R, G, B, FrameStart
  );
endinterface

// File: rtl/video_pattern_timing_gen.sv
// ----------------------------------------------------------------------------
// video_pattern_timing_gen
// Parametrised video timing (HS/VS/DE) plus selectable test patterns.
// Ports:
//   Clock : pixel clock
//   Reset : asynchronous, active-high
//   vid   : video_pattern_timing_gen_if.master (Enable, Mode in;
//           HS, VS, DE, R, G, B, FrameStart out)
// All outputs are registered one clock after the counter state they describe.
// Modes: 0 white, 1 eight colour bars, 2 grey ramp, 3 checker, 4 grid,
//        5-7 black.
// Optional build macro PATTERN_SCROLL_EN: adds a per-frame counter used as a
// horizontal offset so the ramp and checker scroll left one pixel per frame.
// ----------------------------------------------------------------------------
module video_pattern_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int COLOR_WIDTH = 8,
  parameter int CHECK_LOG2  = 5
) (
  input logic                         Clock,
  input logic                         Reset,
  video_pattern_timing_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = H_ACTIVE / 8;
  localparam int BSW     = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0]          H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]          V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [BSW-1:0]         B_LAST    = BSW'(BW - 1);
  localparam logic [31:0]            HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]            HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]            VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]            VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]            CELL_MASK = (32'd1 << CHECK_LOG2) - 32'd1;
  localparam logic [COLOR_WIDTH-1:0] FULL      = '1;
  localparam logic [COLOR_WIDTH-1:0] ZERO      = '0;

  logic [HW-1:0]  hCnt, hCntNext;
  logic [VW-1:0]  vCnt, vCntNext;
  logic [2:0]     modeQ, modeQNext;
  logic [BSW-1:0] barSub, barSubNext;   // pixel position inside current bar
  logic [2:0]     barIdx, barIdxNext;   // current bar, clamps at 7
  logic [COLOR_WIDTH-1:0] offset;

  logic frameStartRaw;
  assign frameStartRaw = (hCnt == '0) && (vCnt == '0);

`ifdef PATTERN_SCROLL_EN
  logic [COLOR_WIDTH-1:0] frameCnt, frameCntNext;

  always_comb begin
    frameCntNext = frameCnt;
    if (vid.Enable && hCnt == H_LAST && vCnt == V_LAST)
      frameCntNext = frameCnt + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) frameCnt <= '0;
    else       frameCnt <= frameCntNext;
  end

  assign offset = frameCnt;
`else
  assign offset = '0;
`endif

  // Counter / bar tracker next state
  always_comb begin
    hCntNext   = hCnt;
    vCntNext   = vCnt;
    modeQNext  = modeQ;
    barSubNext = barSub;
    barIdxNext = barIdx;
    if (!vid.Enable) begin
      hCntNext   = '0;
      vCntNext   = '0;
      barSubNext = '0;
      barIdxNext = '0;
    end else begin
      if (frameStartRaw) modeQNext = vid.Mode;
      if (hCnt == H_LAST) begin
        hCntNext   = '0;
        barSubNext = '0;
        barIdxNext = '0;
        vCntNext   = (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
      end else begin
        hCntNext = hCnt + 1'b1;
        if (barSub == B_LAST) begin
          barSubNext = '0;
          if (barIdx != 3'd7) barIdxNext = barIdx + 1'b1;
        end else begin
          barSubNext = barSub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hCnt   <= '0;
      vCnt   <= '0;
      modeQ  <= '0;
      barSub <= '0;
      barIdx <= '0;
    end else begin
      hCnt   <= hCntNext;
      vCnt   <= vCntNext;
      modeQ  <= modeQNext;
      barSub <= barSubNext;
      barIdx <= barIdxNext;
    end
  end

  // Pixel / sync generation from the current counter state
  logic [2:0]             effMode;
  logic [31:0]            hExt, vExt, xExt;
  logic                   deRaw, hsRaw, vsRaw, gridOn, checkOn;
  logic [COLOR_WIDTH-1:0] rNext, gNext, bNext;

  always_comb begin
    // On the frame-start cycle the new Mode already applies to pixel (0,0).
    effMode = frameStartRaw ? vid.Mode : modeQ;
    hExt    = 32'(hCnt);
    vExt    = 32'(vCnt);
    xExt    = hExt + 32'(offset);
    deRaw   = (hExt < 32'(H_ACTIVE)) && (vExt < 32'(V_ACTIVE));
    hsRaw   = (hExt >= HS_START) && (hExt < HS_END);
    vsRaw   = (vExt >= VS_START) && (vExt < VS_END);
    checkOn = (((xExt ^ vExt) >> CHECK_LOG2) & 32'd1) != 32'd0;
    gridOn  = (hExt == 32'd0) || (hExt == 32'(H_ACTIVE - 1)) ||
              (vExt == 32'd0) || (vExt == 32'(V_ACTIVE - 1)) ||
              ((hExt & CELL_MASK) == 32'd0) || ((vExt & CELL_MASK) == 32'd0);
    rNext = ZERO;
    gNext = ZERO;
    bNext = ZERO;
    if (deRaw) begin
      case (effMode)
        3'd0: begin rNext = FULL; gNext = FULL; bNext = FULL; end
        3'd1: begin
          rNext = barIdx[1] ? ZERO : FULL;
          gNext = barIdx[2] ? ZERO : FULL;
          bNext = barIdx[0] ? ZERO : FULL;
        end
        3'd2: begin
          rNext = COLOR_WIDTH'(xExt);
          gNext = COLOR_WIDTH'(xExt);
          bNext = COLOR_WIDTH'(xExt);
        end
        3'd3: begin
          rNext = checkOn ? FULL : ZERO;
          gNext = checkOn ? FULL : ZERO;
          bNext = checkOn ? FULL : ZERO;
        end
        3'd4: begin
          rNext = gridOn ? FULL : ZERO;
          gNext = gridOn ? FULL : ZERO;
          bNext = gridOn ? FULL : ZERO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset || !vid.Enable) begin
      vid.HS         <= !HS_POL;
      vid.VS         <= !VS_POL;
      vid.DE         <= 1'b0;
      vid.R          <= ZERO;
      vid.G          <= ZERO;
      vid.B          <= ZERO;
      vid.FrameStart <= 1'b0;
    end else begin
      vid.HS         <= hsRaw ? HS_POL : !HS_POL;
      vid.VS         <= vsRaw ? VS_POL : !VS_POL;
      vid.DE         <= deRaw;
      vid.R          <= rNext;
      vid.G          <= gNext;
      vid.B          <= bNext;
      vid.FrameStart <= frameStartRaw;
    end
  end

endmodule

// File: tb/tb_video_pattern_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_pattern_timing_gen
// Randomised bench: a driver issues Enable/Mode each cycle and pushes the
// expected registered output into a queue; a monitor pops and compares after
// every rising edge. The reference derives h/v from the number of consecutive
// enabled cycles with plain division/modulo.
// ----------------------------------------------------------------------------
module tb_video_pattern_timing_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 4,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int CL2 = 2;
  localparam int CELL = 1 << CL2;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  video_pattern_timing_gen_if #(.COLOR_WIDTH(8)) vid ();

  video_pattern_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_WIDTH(8), .CHECK_LOG2(CL2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .vid(vid)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       hs, vs, de, fs;
    logic [7:0] r, g, b;
  } vec_t;

  vec_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference state
  int   tRun   = 0;   // consecutive enabled cycles since last idle/reset
  int   refMode = 0;
  int   frames = 0;

  function automatic vec_t idleVec();
    vec_t e;
    e = '0;
    e.hs = !HS_POL;
    e.vs = !VS_POL;
    return e;
  endfunction

  function automatic vec_t model(int h, int v, int mode, int off);
    vec_t e;
    int x, bar;
    bit on;
    e = idleVec();
    e.fs = (h == 0 && v == 0);
    e.de = (h < HA) && (v < VA);
    e.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : !HS_POL;
    e.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : !VS_POL;
    if (e.de) begin
      x = h + off;
      case (mode)
        0: begin e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF; end
        1: begin
          bar = h / (HA / 8);
          if (bar > 7) bar = 7;
          e.r = ((bar / 2) % 2 == 1) ? 8'h00 : 8'hFF;
          e.g = ((bar / 4) % 2 == 1) ? 8'h00 : 8'hFF;
          e.b = (bar % 2 == 1)       ? 8'h00 : 8'hFF;
        end
        2: begin e.r = 8'(x % 256); e.g = 8'(x % 256); e.b = 8'(x % 256); end
        3: begin
          on = (((x / CELL) + (v / CELL)) % 2) == 1;
          e.r = on ? 8'hFF : 8'h00; e.g = e.r; e.b = e.r;
        end
        4: begin
          on = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1) ||
               (h % CELL == 0) || (v % CELL == 0);
          e.r = on ? 8'hFF : 8'h00; e.g = e.r; e.b = e.r;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue the output expected after next edge.
  task automatic issue(input bit en, input logic [2:0] mode);
    int h, v, off;
    vid.Enable = en;
    vid.Mode   = mode;
    if (Reset) begin
      expQ.push_back(idleVec());
      tRun = 0; refMode = 0; frames = 0;
    end else if (!en) begin
      expQ.push_back(idleVec());
      tRun = 0;
    end else begin
      h = tRun % HT;
      v = (tRun / HT) % VT;
      if (h == 0 && v == 0) refMode = int'(mode);
`ifdef PATTERN_SCROLL_EN
      off = frames % 256;
`else
      off = 0;
`endif
      expQ.push_back(model(h, v, refMode, off));
      if (h == HT - 1 && v == VT - 1) frames++;
      tRun++;
    end
  endtask

  function automatic vec_t sampleDut();
    vec_t g;
    g.hs = vid.HS; g.vs = vid.VS; g.de = vid.DE; g.fs = vid.FrameStart;
    g.r = vid.R; g.g = vid.G; g.b = vid.B;
    return g;
  endfunction

  // Monitor: one comparison per clock
  initial begin
    vec_t want, got;
    forever begin
      @(posedge Clock);
      #1;
      got = sampleDut();
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL queue @%0t: got output with no expectation queued", $time);
      end else begin
        want = expQ.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL video @%0t: got hs=%b vs=%b de=%b fs=%b rgb=%h_%h_%h want hs=%b vs=%b de=%b fs=%b rgb=%h_%h_%h",
                   $time, got.hs, got.vs, got.de, got.fs, got.r, got.g, got.b,
                   want.hs, want.vs, want.de, want.fs, want.r, want.g, want.b);
        end
      end
      $display("vec %0d t=%0t hs=%b vs=%b de=%b fs=%b rgb=%h_%h_%h", vectors, $time,
               got.hs, got.vs, got.de, got.fs, got.r, got.g, got.b);
    end
  end

  // Driver
  initial begin
    logic [2:0] m;
    bit   en;
    int   offCnt, nextReset, resets;
    bit   rstHold;
    vec_t got;
    m = 3'd0; offCnt = 0; nextReset = 1700; resets = 0; rstHold = 0;
    vid.Enable = 1'b0;
    vid.Mode   = 3'd0;
    issue(1'b0, 3'd0);
    repeat (3) begin
      @(negedge Clock);
      issue(1'b0, 3'd0);
    end
    @(negedge Clock);
    Reset = 1'b0;
    issue(1'b0, 3'd0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge Clock);
      if (c < 1600) m = 3'((c / 200) % 8);
      else if ($urandom_range(0, 99) == 0) m = 3'($urandom_range(0, 7));

      if (offCnt > 0) begin
        offCnt--; en = 1'b0;
      end else if (c >= 1600 && $urandom_range(0, 299) == 0) begin
        offCnt = int'($urandom_range(0, 3)); en = 1'b0;
      end else begin
        en = 1'b1;
      end

      if (rstHold) begin
        Reset = 1'b0;
        rstHold = 1'b0;
      end else if (c >= nextReset && resets < 3 && en &&
                   (tRun % HT) >= 3 && (tRun % HT) <= 12 && ((tRun / HT) % VT) < VA) begin
        // Asynchronous reset in the middle of active video
        #2 Reset = 1'b1;
        #1 got = sampleDut();
        vectors++;
        if (got !== idleVec()) begin
          miscompares++;
          $display("FAIL async_reset @%0t: got hs=%b vs=%b de=%b fs=%b rgb=%h_%h_%h want idle outputs",
                   $time, got.hs, got.vs, got.de, got.fs, got.r, got.g, got.b);
        end
        rstHold = 1'b1;
        resets++;
        nextReset = c + 600;
      end
      issue(en, m);
    end

    @(posedge Clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
